alu_ctl_sequencer: RTL and testbench
====================================

Name: alu_ctl_sequencer

Overview:
- Multi-cycle MIPS control unit. It decodes Opcode/Funct, steps a Moore FSM through fetch/decode/execute/memory/writeback, and drives the datapath muxes and enables.
- Produces ALU_Ctl for the 32-bit ALU and consumes that ALU's Zero_Flag for branch resolution, i.e. it is the issuing end of the ALU_Ctl/Zero_Flag interface.
- Sits between instruction register, memory port and register file.

Parameters:
COUNT_W, 32, width of retired-instruction counter
TRAP_ON_ILLEGAL, 1, 1: illegal op enters TRAP and halts; 0: illegal op retires as NOP

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
Opcode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero_Flag  in  1  ALU zero result
Mem_Ready  in  1  memory access completes this cycle
ALU_Ctl  out  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
ALUSrcA  out  1  0 PC, 1 reg A
ALUSrcB  out  2  00 reg B, 01 const 4, 10 ext imm, 11 ext imm<<2
ExtOp  out  1  0 sign-extend, 1 zero-extend
IorD  out  1  0 PC address, 1 ALUOut address
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load IR
RegDst  out  1  0 rt, 1 rd
MemtoReg  out  1  0 ALUOut, 1 MDR
RegWrite  out  1  register-file write
PCSource  out  2  00 ALU, 01 ALUOut, 10 jump target
PC_En  out  1  PC load, branch condition already resolved
Illegal_Op  out  1  sticky illegal-instruction flag
Retired  out  COUNT_W  retired-instruction count

Behaviour:
- State register and counters use async reset.
- While rst is high: state = FETCH, Retired = 0, Illegal_Op = 0, all enables/requests = 0, ALU_Ctl = 0010, all mux selects = 0.
- Outputs are Moore, decoded from the current state, except PC_En/IRWrite in FETCH and the memory-state exits, which are gated by Mem_Ready.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALU_Ctl=ADD, PCSource=00. IRWrite = PC_En = Mem_Ready. Hold in FETCH until Mem_Ready, then go to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state by Opcode:
  - 000000 -> R_EXEC
  - 100011/101011 -> MEM_ADDR
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - 001000/001100/001101/001010 -> I_EXEC
  - else illegal
- R_EXEC: ALUSrcA=1, ALUSrcB=00. ALU_Ctl by Funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT. Any other Funct is illegal. Next state R_WB.
- R_WB: RegDst=1, MemtoReg=0, RegWrite=1, retire, go to FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ExtOp=0, ADD. Next state MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead=1, IorD=1. Wait for Mem_Ready, then go to MEM_WB.
- MEM_WB: RegDst=0, MemtoReg=1, RegWrite=1, retire, go to FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Wait for Mem_Ready, then retire and go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSource=01. PC_En = Zero_Flag for beq, ~Zero_Flag for bne. Retire, go to FETCH.
- JUMP: PCSource=10, PC_En=1, retire, go to FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10.
  - addi: ADD, ExtOp=0
  - andi: AND, ExtOp=1
  - ori: OR, ExtOp=1
  - slti: SLT, ExtOp=0
  - Next state I_WB.
- I_WB: RegDst=0, MemtoReg=0, RegWrite=1, retire, go to FETCH.
- Illegal op (opcode or funct):
  - Illegal_Op is set to 1 and stays set until reset.
  - TRAP_ON_ILLEGAL=1: go to TRAP. TRAP drives all enables 0 and remains there until rst.
  - TRAP_ON_ILLEGAL=0: go to FETCH, no RegWrite, Retired incremented.
- Retired increments by exactly 1 on the retiring cycle and wraps modulo 2^COUNT_W.
- Mem_Ready is ignored outside FETCH/MEM_READ/MEM_WRITE.
- Reset asserted mid-instruction aborts it. That instruction is not retired and no write enable is asserted after rst rises.

Decomposition:
- Package alu_ctl_pkg holds:
  - state enum FETCH..TRAP
  - ALU_Ctl codes
  - opcode and funct constants
  - ALUSrcB/PCSource encodings
- Sub-module alu_funct_decode: combinational (Funct, class) -> ALU_Ctl, valid. It is shared with a future single-cycle variant.

Test Plan:
- add (Opcode 000000, Funct 100000), Mem_Ready=1 -> FETCH, DECODE, R_EXEC (ALU_Ctl=0010), R_WB (RegWrite=1, RegDst=1); Retired 0 -> 1 after 4 cycles.
- lw with Mem_Ready low 3 cycles in MEM_READ -> MemRead/IorD held 1 for 4 cycles; RegWrite=1, MemtoReg=1 once, in MEM_WB; 5 + 3 = 8 cycles total.
- beq with Zero_Flag=1 -> PC_En=1, PCSource=01 in BRANCH. bne with Zero_Flag=1 -> PC_En=0 in BRANCH.
- andi -> ExtOp=1, ALU_Ctl=0000, ALUSrcB=10. slti -> ExtOp=0, ALU_Ctl=0111.
- Opcode 111111 with TRAP_ON_ILLEGAL=1 -> Illegal_Op=1, FSM parks in TRAP, all enables 0 for 20 cycles, Retired unchanged. With TRAP_ON_ILLEGAL=0 -> back to FETCH, Retired+1, no RegWrite.
- Assert rst asynchronously during MEM_WRITE -> MemWrite drops the same instant, state = FETCH, Retired = 0. Counter preset to 2^COUNT_W-1 -> wraps to 0 on the next retire.

Source files
------------

// File: rtl/alu_ctl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control sequencer.
// Covers FSM states, ALU control codes, opcode/funct values and datapath mux selects.
package alu_ctl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StRExec,
        StRWb,
        StMemAddr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StBranch,
        StJump,
        StIExec,
        StIWb,
        StTrap
    } state_e;

    // Operation class handed to the ALU control decoder.
    typedef enum logic [2:0] {
        ClsAdd,
        ClsSub,
        ClsAnd,
        ClsOr,
        ClsSlt,
        ClsFunct
    } alu_class_e;

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluSlt = 4'b0111;
    localparam logic [3:0] AluNor = 4'b1100;

    localparam logic [5:0] OpRType = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpAndi  = 6'b001100;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpSlti  = 6'b001010;

    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnNor = 6'b100111;
    localparam logic [5:0] FnSlt = 6'b101010;

    localparam logic [1:0] SrcBReg   = 2'b00;
    localparam logic [1:0] SrcBFour  = 2'b01;
    localparam logic [1:0] SrcBImm   = 2'b10;
    localparam logic [1:0] SrcBImmSh = 2'b11;

    localparam logic [1:0] PcAlu    = 2'b00;
    localparam logic [1:0] PcAluOut = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;

endpackage

// File: rtl/alu_funct_decode.sv
// Combinational ALU control decode from operation class and R-type funct field.
// valid_o is low only for an unrecognised funct in the R-type class.
module alu_funct_decode
    import alu_ctl_pkg::*;
(
    input  logic [5:0]  funct_i,
    input  alu_class_e  class_i,
    output logic [3:0]  alu_ctl_o,
    output logic        valid_o
);

    always_comb begin
        alu_ctl_o = AluAdd;
        valid_o   = 1'b1;
        unique case (class_i)
            ClsAdd: alu_ctl_o = AluAdd;
            ClsSub: alu_ctl_o = AluSub;
            ClsAnd: alu_ctl_o = AluAnd;
            ClsOr:  alu_ctl_o = AluOr;
            ClsSlt: alu_ctl_o = AluSlt;
            ClsFunct: begin
                case (funct_i)
                    FnAdd:   alu_ctl_o = AluAdd;
                    FnSub:   alu_ctl_o = AluSub;
                    FnAnd:   alu_ctl_o = AluAnd;
                    FnOr:    alu_ctl_o = AluOr;
                    FnNor:   alu_ctl_o = AluNor;
                    FnSlt:   alu_ctl_o = AluSlt;
                    default: valid_o   = 1'b0;
                endcase
            end
            default: alu_ctl_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/alu_ctl_sequencer.sv
// Multi-cycle MIPS control unit: Moore FSM over fetch/decode/execute/memory/writeback
// driving datapath mux selects and enables, with retired-instruction count and illegal-op trap.
module alu_ctl_sequencer
    import alu_ctl_pkg::*;
#(
    parameter int unsigned COUNT_W         = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         Opcode,
    input  logic [5:0]         Funct,
    input  logic               Zero_Flag,
    input  logic               Mem_Ready,
    output logic [3:0]         ALU_Ctl,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               ExtOp,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [1:0]         PCSource,
    output logic               PC_En,
    output logic               Illegal_Op,
    output logic [COUNT_W-1:0] Retired
);

    state_e             state_q, state_d;
    logic [COUNT_W-1:0] retired_q;
    logic               illegal_q;
    logic               retire;
    logic               illegal_hit;
    alu_class_e         alu_class;
    logic [3:0]         dec_ctl;
    logic               dec_valid;

    alu_funct_decode u_funct_decode (
        .funct_i   (Funct),
        .class_i   (alu_class),
        .alu_ctl_o (dec_ctl),
        .valid_o   (dec_valid)
    );

    always_comb begin
        alu_class = ClsAdd;
        unique case (state_q)
            StRExec:  alu_class = ClsFunct;
            StBranch: alu_class = ClsSub;
            StIExec: begin
                case (Opcode)
                    OpAndi:  alu_class = ClsAnd;
                    OpOri:   alu_class = ClsOr;
                    OpSlti:  alu_class = ClsSlt;
                    default: alu_class = ClsAdd;
                endcase
            end
            default: alu_class = ClsAdd;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        illegal_hit = 1'b0;
        case (state_q)
            StFetch: if (Mem_Ready) state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OpRType:                        state_d = StRExec;
                    OpLw, OpSw:                     state_d = StMemAddr;
                    OpBeq, OpBne:                   state_d = StBranch;
                    OpJ:                            state_d = StJump;
                    OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
                    default:                        illegal_hit = 1'b1;
                endcase
            end
            StRExec: begin
                if (dec_valid) state_d = StRWb;
                else           illegal_hit = 1'b1;
            end
            StMemAddr: state_d = (Opcode == OpLw) ? StMemRead : StMemWrite;
            StMemRead: if (Mem_Ready) state_d = StMemWb;
            StMemWrite: begin
                if (Mem_Ready) begin
                    retire  = 1'b1;
                    state_d = StFetch;
                end
            end
            StRWb, StMemWb, StBranch, StJump, StIWb: begin
                retire  = 1'b1;
                state_d = StFetch;
            end
            StIExec: state_d = StIWb;
            StTrap:  state_d = StTrap;
            default: state_d = StFetch;
        endcase
        // Illegal ops either park in TRAP or retire as a NOP without any register write.
        if (illegal_hit) begin
            if (TRAP_ON_ILLEGAL) begin
                state_d = StTrap;
            end else begin
                state_d = StFetch;
                retire  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (retire)      retired_q <= retired_q + COUNT_W'(1);
            if (illegal_hit) illegal_q <= 1'b1;
        end
    end

    // Everything is held at its idle value while rst is high, including the FETCH read request.
    always_comb begin
        ALUSrcA  = 1'b0;
        ALUSrcB  = SrcBReg;
        ExtOp    = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        PCSource = PcAlu;
        PC_En    = 1'b0;
        if (!rst) begin
            case (state_q)
                StFetch: begin
                    MemRead = 1'b1;
                    ALUSrcB = SrcBFour;
                    IRWrite = Mem_Ready;
                    PC_En   = Mem_Ready;
                end
                StDecode: ALUSrcB = SrcBImmSh;
                StRExec:  ALUSrcA = 1'b1;
                StRWb: begin
                    RegDst   = 1'b1;
                    RegWrite = 1'b1;
                end
                StMemAddr: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcBImm;
                end
                StMemRead: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                StMemWb: begin
                    MemtoReg = 1'b1;
                    RegWrite = 1'b1;
                end
                StMemWrite: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                end
                StBranch: begin
                    ALUSrcA  = 1'b1;
                    PCSource = PcAluOut;
                    PC_En    = (Opcode == OpBne) ? ~Zero_Flag : Zero_Flag;
                end
                StJump: begin
                    PCSource = PcJump;
                    PC_En    = 1'b1;
                end
                StIExec: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SrcBImm;
                    ExtOp   = (Opcode == OpAndi) || (Opcode == OpOri);
                end
                StIWb:   RegWrite = 1'b1;
                default: ;
            endcase
        end
    end

    assign ALU_Ctl    = dec_ctl;
    assign Illegal_Op = illegal_q;
    assign Retired    = retired_q;

endmodule

// File: tb/tb_alu_ctl_sequencer.sv
// Directed bench for alu_ctl_sequencer: a trapping 32-bit-counter instance and a
// non-trapping 3-bit-counter instance, checked with immediate assertions.
module tb_alu_ctl_sequencer;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic [5:0] opcode, funct;
    logic zero_flag, mem_ready;

    logic [3:0] a_alu, b_alu;
    logic a_sa, b_sa, a_ext, b_ext, a_iord, b_iord, a_mrd, b_mrd, a_mwr, b_mwr;
    logic a_irw, b_irw, a_rdst, b_rdst, a_m2r, b_m2r, a_rw, b_rw, a_pce, b_pce;
    logic [1:0] a_sb, b_sb, a_pcs, b_pcs;
    logic a_ill, b_ill;
    logic [31:0] a_ret;
    logic [2:0]  b_ret;
    logic [17:0] ctl_a, ctl_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_ctl_sequencer #(.COUNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut_a (
        .clk(clk), .rst(rst_a), .Opcode(opcode), .Funct(funct), .Zero_Flag(zero_flag),
        .Mem_Ready(mem_ready), .ALU_Ctl(a_alu), .ALUSrcA(a_sa), .ALUSrcB(a_sb), .ExtOp(a_ext),
        .IorD(a_iord), .MemRead(a_mrd), .MemWrite(a_mwr), .IRWrite(a_irw), .RegDst(a_rdst),
        .MemtoReg(a_m2r), .RegWrite(a_rw), .PCSource(a_pcs), .PC_En(a_pce),
        .Illegal_Op(a_ill), .Retired(a_ret)
    );

    alu_ctl_sequencer #(.COUNT_W(3), .TRAP_ON_ILLEGAL(1'b0)) dut_b (
        .clk(clk), .rst(rst_b), .Opcode(opcode), .Funct(funct), .Zero_Flag(zero_flag),
        .Mem_Ready(mem_ready), .ALU_Ctl(b_alu), .ALUSrcA(b_sa), .ALUSrcB(b_sb), .ExtOp(b_ext),
        .IorD(b_iord), .MemRead(b_mrd), .MemWrite(b_mwr), .IRWrite(b_irw), .RegDst(b_rdst),
        .MemtoReg(b_m2r), .RegWrite(b_rw), .PCSource(b_pcs), .PC_En(b_pce),
        .Illegal_Op(b_ill), .Retired(b_ret)
    );

    assign ctl_a = {a_alu, a_sa, a_sb, a_ext, a_iord, a_mrd, a_mwr, a_irw, a_rdst, a_m2r, a_rw,
                    a_pcs, a_pce};
    assign ctl_b = {b_alu, b_sa, b_sb, b_ext, b_iord, b_mrd, b_mwr, b_irw, b_rdst, b_m2r, b_rw,
                    b_pcs, b_pce};

    function automatic logic [17:0] mk(logic [3:0] alu, logic sa, logic [1:0] sb, logic ext,
                                       logic iord, logic mrd, logic mwr, logic irw, logic rdst,
                                       logic m2r, logic rw, logic [1:0] pcs, logic pce);
        return {alu, sa, sb, ext, iord, mrd, mwr, irw, rdst, m2r, rw, pcs, pce};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic [17:0] obs, input logic [17:0] exp,
                           input logic [17:0] mask);
        chk(tag, {14'd0, obs & mask}, {14'd0, exp & mask});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [17:0] m_full, m_en, m_fetch, m_exec, m_ext, m_mem, m_wb, m_br, m_jmp;
    logic [17:0] w_rst, w_dec, w_wb_r, w_wb_m, w_wb_i, w_mrd, w_mwr, w_jmp, w_addr;

    initial begin
        m_full  = 18'h3FFFF;
        m_en    = mk(4'h0, 0, 2'b00, 0, 0, 1, 1, 1, 0, 0, 1, 2'b00, 1);
        m_fetch = mk(4'hF, 1, 2'b11, 0, 1, 1, 1, 1, 0, 0, 1, 2'b11, 1);
        m_exec  = mk(4'hF, 1, 2'b11, 0, 0, 1, 1, 1, 0, 0, 1, 2'b00, 1);
        m_ext   = mk(4'hF, 1, 2'b11, 1, 0, 1, 1, 1, 0, 0, 1, 2'b00, 1);
        m_mem   = mk(4'h0, 0, 2'b00, 0, 1, 1, 1, 1, 0, 0, 1, 2'b00, 1);
        m_wb    = mk(4'h0, 0, 2'b00, 0, 0, 1, 1, 1, 1, 1, 1, 2'b00, 1);
        m_br    = mk(4'hF, 1, 2'b11, 0, 0, 1, 1, 1, 0, 0, 1, 2'b11, 1);
        m_jmp   = mk(4'h0, 0, 2'b00, 0, 0, 1, 1, 1, 0, 0, 1, 2'b11, 1);
        w_rst   = mk(4'b0010, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        w_dec   = mk(4'b0010, 0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        w_addr  = mk(4'b0010, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
        w_wb_r  = mk(4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0, 1, 2'b00, 0);
        w_wb_m  = mk(4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0);
        w_wb_i  = mk(4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0);
        w_mrd   = mk(4'h0, 0, 2'b00, 0, 1, 1, 0, 0, 0, 0, 0, 2'b00, 0);
        w_mwr   = mk(4'h0, 0, 2'b00, 0, 1, 0, 1, 0, 0, 0, 0, 2'b00, 0);
        w_jmp   = mk(4'h0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 1);

        rst_a = 1'b1; rst_b = 1'b1;
        opcode = 6'b000000; funct = 6'b100000; zero_flag = 1'b0; mem_ready = 1'b0;

        // Reset values, while rst is still high.
        #3;
        chk_ctl("reset_ctl", ctl_a, w_rst, m_full);
        chk("reset_retired", a_ret, 32'd0);
        chk("reset_illegal", {31'd0, a_ill}, 32'd0);
        tick(); tick();
        chk_ctl("reset_ctl_hold", ctl_a, w_rst, m_full);
        rst_a = 1'b0;

        // FETCH holds while memory is not ready.
        #1 chk_ctl("fetch_wait", ctl_a, mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0),
                   m_fetch);
        tick();
        chk_ctl("fetch_still", ctl_a, mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0),
                m_fetch);

        // add
        mem_ready = 1'b1;
        #1 chk_ctl("add_fetch", ctl_a, mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1),
                   m_fetch);
        tick(); chk_ctl("add_decode", ctl_a, w_dec, m_exec);
        tick(); chk_ctl("add_rexec", ctl_a, mk(4'b0010, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0),
                        m_exec);
        chk("add_retired_mid", a_ret, 32'd0);
        tick(); chk_ctl("add_rwb", ctl_a, w_wb_r, m_wb);
        tick(); chk("add_retired", a_ret, 32'd1);

        // lw with three wait cycles in MEM_READ
        opcode = 6'b100011;
        tick(); chk_ctl("lw_decode", ctl_a, w_dec, m_exec);
        tick(); chk_ctl("lw_memaddr", ctl_a, w_addr, m_ext);
        tick(); mem_ready = 1'b0;
        #1 chk_ctl("lw_memread0", ctl_a, w_mrd, m_mem);
        for (int i = 1; i < 3; i++) begin
            tick(); chk_ctl("lw_memread_wait", ctl_a, w_mrd, m_mem);
        end
        tick(); mem_ready = 1'b1;
        #1 chk_ctl("lw_memread3", ctl_a, w_mrd, m_mem);
        tick(); chk_ctl("lw_memwb", ctl_a, w_wb_m, m_wb);
        chk("lw_retired_mid", a_ret, 32'd1);
        tick(); chk("lw_retired", a_ret, 32'd2);

        // beq: PC_En follows Zero_Flag
        opcode = 6'b000100; zero_flag = 1'b1;
        tick(); tick();
        chk_ctl("beq_z1", ctl_a, mk(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1), m_br);
        zero_flag = 1'b0;
        #1 chk_ctl("beq_z0", ctl_a, mk(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0), m_br);
        tick(); chk("beq_retired", a_ret, 32'd3);

        // bne: PC_En is the inverse of Zero_Flag
        opcode = 6'b000101; zero_flag = 1'b1;
        tick(); tick();
        chk_ctl("bne_z1", ctl_a, mk(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0), m_br);
        zero_flag = 1'b0;
        #1 chk_ctl("bne_z0", ctl_a, mk(4'b0110, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1), m_br);
        tick(); chk("bne_retired", a_ret, 32'd4);

        // andi, slti
        opcode = 6'b001100;
        tick(); tick();
        chk_ctl("andi_iexec", ctl_a, mk(4'b0000, 1, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), m_ext);
        tick(); chk_ctl("andi_iwb", ctl_a, w_wb_i, m_wb);
        tick(); chk("andi_retired", a_ret, 32'd5);
        opcode = 6'b001010;
        tick(); tick();
        chk_ctl("slti_iexec", ctl_a, mk(4'b0111, 1, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0), m_ext);
        tick(); chk_ctl("slti_iwb", ctl_a, w_wb_i, m_wb);
        tick(); chk("slti_retired", a_ret, 32'd6);

        // j
        opcode = 6'b000010;
        tick(); tick(); chk_ctl("j_jump", ctl_a, w_jmp, m_jmp);
        tick(); chk("j_retired", a_ret, 32'd7);

        // sw with one wait cycle
        opcode = 6'b101011;
        tick(); tick(); chk_ctl("sw_memaddr", ctl_a, w_addr, m_ext);
        tick(); mem_ready = 1'b0;
        #1 chk_ctl("sw_memwrite0", ctl_a, w_mwr, m_mem);
        tick(); mem_ready = 1'b1;
        #1 chk_ctl("sw_memwrite1", ctl_a, w_mwr, m_mem);
        chk("sw_retired_mid", a_ret, 32'd7);
        tick(); chk("sw_retired", a_ret, 32'd8);

        // Illegal opcode parks the trapping instance in TRAP.
        opcode = 6'b111111;
        tick(); chk_ctl("ill_decode", ctl_a, w_dec, m_exec);
        chk("ill_flag_pre", {31'd0, a_ill}, 32'd0);
        tick();
        for (int i = 0; i < 20; i++) begin
            chk_ctl("trap_enables", ctl_a, 18'd0, m_en);
            chk("trap_retired", a_ret, 32'd8);
            chk("trap_flag", {31'd0, a_ill}, 32'd1);
            tick();
        end

        // Reset clears the trap and the sticky flag.
        rst_a = 1'b1;
        #1 chk("trap_rst_flag", {31'd0, a_ill}, 32'd0);
        tick(); rst_a = 1'b0;
        #1 chk_ctl("trap_rst_fetch", ctl_a,
                   mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1), m_fetch);

        // One add, then a sw aborted by an asynchronous reset inside MEM_WRITE.
        opcode = 6'b000000; funct = 6'b100000;
        repeat (4) tick();
        chk("pre_abort_retired", a_ret, 32'd1);
        opcode = 6'b101011;
        tick(); tick(); tick(); mem_ready = 1'b0;
        #1 chk_ctl("abort_memwrite", ctl_a, w_mwr, m_mem);
        #1 rst_a = 1'b1;
        #1 chk_ctl("abort_ctl", ctl_a, w_rst, m_full);
        chk("abort_retired", a_ret, 32'd0);
        tick(); tick(); rst_a = 1'b0;
        #1 chk_ctl("abort_fetch", ctl_a,
                   mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0), m_fetch);

        // Non-trapping instance, 3-bit counter.
        rst_a = 1'b1; rst_b = 1'b0; mem_ready = 1'b1;
        opcode = 6'b111111;
        tick(); chk_ctl("nt_ill_decode", ctl_b, w_dec, m_exec);
        tick(); chk_ctl("nt_ill_fetch", ctl_b,
                        mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1), m_fetch);
        chk("nt_ill_retired", {29'd0, b_ret}, 32'd1);
        chk("nt_ill_flag", {31'd0, b_ill}, 32'd1);

        // Illegal funct retires as a NOP without passing through R_WB.
        opcode = 6'b000000; funct = 6'b111111;
        tick(); tick();
        chk_ctl("nt_fn_rexec", ctl_b, 18'd0, m_en);
        tick(); chk_ctl("nt_fn_fetch", ctl_b,
                        mk(4'b0010, 0, 2'b01, 0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 1), m_fetch);
        chk("nt_fn_retired", {29'd0, b_ret}, 32'd2);

        // Five jumps bring the counter to its maximum, the sixth wraps it.
        opcode = 6'b000010;
        for (int i = 0; i < 5; i++) begin
            repeat (3) tick();
        end
        chk("nt_ret_max", {29'd0, b_ret}, 32'd7);
        repeat (3) tick();
        chk("nt_ret_wrap", {29'd0, b_ret}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
